// File: rtl/option_packet_queue.sv
// option_packet_queue: DEPTH-entry FIFO of packed option packets feeding the
// Black-Scholes engine. The head entry is unpacked onto the operand outputs;
// a rising edge of bs_ready pops it, followed by a COOLDOWN-cycle hold-off.
// Packets arriving while full are dropped and counted.
module option_packet_queue #(
    parameter int DEPTH    = 4,
    parameter int FIELD_W  = 32,
    parameter int ID_W     = 31,
    parameter int COOLDOWN = 50,
    parameter int CD_W     = 8,
    parameter int DROP_W   = 16,
    localparam int PKT_W   = ID_W + 1 + 5 * FIELD_W,
    localparam int AW      = $clog2(DEPTH),
    localparam int OW      = AW + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic [PKT_W-1:0]   FullPacket,
    output logic               in_ready,
    input  logic               bs_ready,
    output logic               out_valid,
    output logic [ID_W:0]      opt_id,
    output logic [FIELD_W-1:0] sptprice,
    output logic [FIELD_W-1:0] strike,
    output logic [FIELD_W-1:0] rate,
    output logic [FIELD_W-1:0] volatility,
    output logic [FIELD_W-1:0] time_r,
    output logic [FIELD_W-1:0] otype,
    output logic [OW-1:0]      occupancy,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_count
);

    typedef enum logic {S_READY = 1'b0, S_COOL = 1'b1} state_t;

    logic [PKT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              prev_bs_q;
    state_t            state_q, state_d;
    logic [CD_W-1:0]   cd_q, cd_d;

    logic              push, drop, pop, rise;
    logic [PKT_W-1:0]  head;

    // Push is decided from registered occupancy only; a same-cycle pop never frees a slot.
    assign in_ready  = (occ_q != OW'(DEPTH));
    assign push      = en && in_ready;
    assign drop      = en && !in_ready;
    assign rise      = bs_ready && !prev_bs_q;
    assign out_valid = (state_q == S_READY) && (occ_q != '0);

    // Head slot is always shown, even when empty (stale contents, zero after reset).
    assign head       = mem_q[rd_ptr_q];
    assign time_r     = head[FIELD_W-1:0];
    assign volatility = head[2*FIELD_W-1:FIELD_W];
    assign rate       = head[3*FIELD_W-1:2*FIELD_W];
    assign strike     = head[4*FIELD_W-1:3*FIELD_W];
    assign sptprice   = head[5*FIELD_W-1:4*FIELD_W];
    assign otype      = {{(FIELD_W-1){1'b0}}, head[5*FIELD_W]};
    assign opt_id     = {head[PKT_W-1:5*FIELD_W+1], 1'b0};
    assign occupancy  = occ_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

    // Packet storage: write the accepted packet into the tail slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= FullPacket;
        end
    end

    // Next-state for pointers, occupancy and drop bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    // Pointer, occupancy, drop and bs_ready-history registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            prev_bs_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            prev_bs_q <= bs_ready;
        end
    end

    // Pop/cooldown FSM: a pop edge starts cd at 1 so the hold-off lasts COOLDOWN cycles.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        pop     = 1'b0;
        case (state_q)
            S_READY: begin
                if (rise && out_valid) begin
                    pop = 1'b1;
                    if (COOLDOWN > 0) begin
                        state_d = S_COOL;
                        cd_d    = CD_W'(1);
                    end
                end
            end
            S_COOL: begin
                if (cd_q == CD_W'(COOLDOWN)) begin
                    state_d = S_READY;
                    cd_d    = '0;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end
            default: state_d = S_READY;
        endcase
    end

    // FSM state and cooldown counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_READY;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
        end
    end

endmodule

// File: tb/tb_option_packet_queue.sv
// Directed bench for option_packet_queue: dut_a uses default parameters,
// dut_b uses COOLDOWN=0 for back-to-back simultaneous push/pop.
module tb_option_packet_queue;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // dut_a signals
    logic         en = 1'b0, bs = 1'b0;
    logic [191:0] pkt = '0;
    logic         in_ready, out_valid, overflow;
    logic [31:0]  opt_id, sptprice, strike, rate, volatility, time_r, otype;
    logic [2:0]   occupancy;
    logic [15:0]  drop_count;

    // dut_b signals
    logic         b_en = 1'b0, b_bs = 1'b0;
    logic [191:0] b_pkt = '0;
    logic         b_in_ready, b_out_valid, b_overflow;
    logic [31:0]  b_opt_id, b_sptprice, b_strike, b_rate, b_volatility, b_time_r, b_otype;
    logic [2:0]   b_occupancy;
    logic [15:0]  b_drop_count;

    int nchk = 0;
    int nerr = 0;

    option_packet_queue dut_a (
        .clock(clock), .reset(reset), .en(en), .FullPacket(pkt), .in_ready(in_ready),
        .bs_ready(bs), .out_valid(out_valid), .opt_id(opt_id), .sptprice(sptprice),
        .strike(strike), .rate(rate), .volatility(volatility), .time_r(time_r),
        .otype(otype), .occupancy(occupancy), .overflow(overflow), .drop_count(drop_count)
    );

    option_packet_queue #(.COOLDOWN(0)) dut_b (
        .clock(clock), .reset(reset), .en(b_en), .FullPacket(b_pkt), .in_ready(b_in_ready),
        .bs_ready(b_bs), .out_valid(b_out_valid), .opt_id(b_opt_id), .sptprice(b_sptprice),
        .strike(b_strike), .rate(b_rate), .volatility(b_volatility), .time_r(b_time_r),
        .otype(b_otype), .occupancy(b_occupancy), .overflow(b_overflow), .drop_count(b_drop_count)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        en = 0; bs = 0; b_en = 0; b_bs = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Packet n: id=n, obit=n[0], fields tagged with n.
    function automatic logic [191:0] mk(input int n);
        logic [30:0] id;
        id = 31'(n);
        return {id, n[0], 32'hA000_0000 + 32'(n), 32'hB000_0000 + 32'(n),
                32'hC000_0000 + 32'(n), 32'hD000_0000 + 32'(n), 32'hE000_0000 + 32'(n)};
    endfunction

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    initial begin
        int cnt;
        #1;
        // reset state
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_inrdy", in_ready, 1'b1);
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_spt", sptprice, 32'h0);
        chk("rst_id", opt_id, 32'h0);
        tick();
        reset = 1'b0;

        // single packet
        en = 1; pkt = 192'h12345679_3F800000_3F8CCCCD_40000000_40400000_40000000;
        tick();
        en = 0;
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_id", opt_id, 32'h12345678);
        chk("t1_otype", otype, 32'h1);
        chk("t1_spt", sptprice, 32'h3F800000);
        chk("t1_strike", strike, 32'h3F8CCCCD);
        chk("t1_rate", rate, 32'h40000000);
        chk("t1_vol", volatility, 32'h40400000);
        chk("t1_time", time_r, 32'h40000000);
        chk("t1_occ", occupancy, 3'd1);

        // pop and cooldown, with a re-pulse during cooldown
        en = 1; pkt = mk(2);
        tick();
        en = 0;
        chk("t2_occ2", occupancy, 3'd2);
        bs = 1;
        tick();
        chk("t2_occ1", occupancy, 3'd1);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            cnt++;
            if (cnt == 10) bs = 0;
            if (cnt == 12) bs = 1;
            tick();
        end
        chk("t2_cool", cnt, 50);
        chk("t2_occ_after", occupancy, 3'd1);
        chk("t2_id", opt_id, 32'h4);
        chk("t2_spt", sptprice, 32'hA000_0002);
        chk("t2_otype", otype, 32'h0);
        bs = 0;

        // fill and overflow
        do_reset();
        en = 1;
        for (int i = 1; i <= 6; i++) begin
            pkt = mk(i);
            tick();
            if (i == 4) chk("t3_inrdy4", in_ready, 1'b0);
        end
        en = 0;
        chk("t3_occ", occupancy, 3'd4);
        chk("t3_drop", drop_count, 16'd2);
        chk("t3_ovf", overflow, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            wait_valid("t3_wait");
            chk("t3_order", opt_id, 32'(k) << 1);
            bs = 1;
            tick();
            bs = 0;
        end
        chk("t3_empty", occupancy, 3'd0);

        // wrap and simultaneous push/pop on dut_b (no cooldown)
        do_reset();
        b_en = 1;
        b_pkt = mk(1); tick();
        b_pkt = mk(2); tick();
        b_en = 0;
        for (int i = 1; i <= 10; i++) begin
            chk("t4_head", b_opt_id, 32'(i) << 1);
            b_bs = 1; b_en = 1; b_pkt = mk(i + 2);
            tick();
            b_bs = 0; b_en = 0;
            chk("t4_occ", b_occupancy, 3'd2);
            tick();
        end
        chk("t4_final", b_opt_id, 32'd11 << 1);

        // level bs_ready pops once
        do_reset();
        en = 1;
        for (int i = 1; i <= 3; i++) begin
            pkt = mk(i);
            tick();
        end
        en = 0;
        bs = 1;
        repeat (100) tick();
        chk("t5_level", occupancy, 3'd2);
        chk("t5_head", opt_id, 32'd2 << 1);
        bs = 0;

        // rising edge on an empty queue is ignored
        do_reset();
        bs = 1;
        tick();
        en = 1; pkt = mk(9);
        tick();
        en = 0;
        chk("t5_e_occ", occupancy, 3'd1);
        chk("t5_e_valid", out_valid, 1'b1);
        bs = 0;

        // asynchronous reset during cooldown
        do_reset();
        en = 1;
        for (int i = 1; i <= 5; i++) begin
            pkt = mk(i);
            tick();
        end
        en = 0;
        chk("t6_drop1", drop_count, 16'd1);
        bs = 1;
        tick();
        bs = 0;
        chk("t6_occ3", occupancy, 3'd3);
        repeat (5) tick();
        #3 reset = 1'b1;
        #1;
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_occ", occupancy, 3'd0);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_drop", drop_count, 16'd0);
        chk("t6_spt", sptprice, 32'h0);
        chk("t6_id", opt_id, 32'h0);
        reset = 1'b0;
        tick();
        en = 1; pkt = mk(7);
        tick();
        en = 0;
        chk("t6_post_valid", out_valid, 1'b1);
        chk("t6_post_id", opt_id, 32'd7 << 1);
        chk("t6_post_occ", occupancy, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
